// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan controller: state encoding, channel
// count, select/counter widths and the settle-load helper.
// Latency: n/a (definitions only). Backpressure: n/a.
//
// Contents:
//   N_CH      number of mux channels scanned per frame
//   SEL_W     width of the mux select
//   CNT_W     width of the settle counter
//   LAST_SEL  select code of the final channel in a scan
//   state_t   controller states IDLE / SCAN / OUT
package mux_scan_ctrl_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Settle values above the counter range saturate rather than wrap, so an
  // oversized parameter still gives the longest settle instead of a short one.
  function automatic logic [CNT_W-1:0] settle_load(input int unsigned s);
    logic [CNT_W-1:0] v;
    if (s > ((1 << CNT_W) - 1)) v = '1;
    else                        v = CNT_W'(s);
    return v;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle between the scan controller and its mux/downstream consumer.
// Latency: n/a (wires only). Backpressure: frame_valid/frame_ready handshake.
//
// Signals:
//   start, cont        scan requests (consumer -> controller)
//   f                  mux output (mux -> controller)
//   sel                mux select (controller -> mux)
//   frame, frame_valid packed samples and qualifier (controller -> consumer)
//   frame_ready        consumer acceptance (consumer -> controller)
//   busy               controller not idle
// Modports: master = controller side, slave = mux/consumer side.
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic             start;
  logic             cont;
  logic             f;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  frame;
  logic             frame_valid;
  logic             frame_ready;
  logic             busy;

  modport master (
    input  start, cont, f, frame_ready,
    output sel, frame, frame_valid, busy
  );

  modport slave (
    output start, cont, f, frame_ready,
    input  sel, frame, frame_valid, busy
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Loadable down-counter timing the settle window after each select change.
// Latency: load takes effect on the next edge; zero is a decode of the count.
// Backpressure: none; counts only while en is high and holds at zero.
//
// Ports:
//   clk, rst_n  clock and async active-low reset
//   load        load value on this edge (has priority over counting)
//   en          decrement on this edge when the count is non-zero
//   value       reload value
//   zero        count is zero
module settle_timer
  import mux_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans mux select 0..3, samples f after a settle window, emits 4-bit frames.
// Latency: frame_valid rises 4*(SETTLE+1) edges after the start edge.
// Backpressure: frame held in OUT until frame_ready; scanning stalls, sel=0.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; aborts any scan in progress
//   bus    mux_scan_ctrl_if.master: start/cont/f/frame_ready in,
//          sel/frame/frame_valid/busy out (all outputs registered)
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 1
)(
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] SETTLE_V = settle_load(SETTLE);

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic [N_CH-2:0]  shadow;   // channels 0..N_CH-2; the last goes straight to frame
  logic [N_CH-1:0]  frame_q;
  logic             frame_valid_q;
  logic             busy_q;

  logic             hs;
  logic             scan_go;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_zero;

  // scan_go covers both ways into SCAN: a start from IDLE, or a completed
  // handshake in OUT with another scan requested. The timer also reloads
  // after every non-final sample so each channel gets a full settle window.
  always_comb begin
    hs       = frame_valid_q & bus.frame_ready;
    scan_go  = ((state == ST_IDLE) & bus.start) |
               ((state == ST_OUT) & hs & (bus.cont | bus.start));
    tmr_load = scan_go |
               ((state == ST_SCAN) & tmr_zero & (sel_q != LAST_SEL));
    tmr_en   = (state == ST_SCAN);
  end

  settle_timer u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .en    (tmr_en),
    .value (SETTLE_V),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sel_q         <= '0;
      shadow        <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sel_q <= '0;
          if (bus.start) begin
            state  <= ST_SCAN;
            busy_q <= 1'b1;
          end
        end

        ST_SCAN: begin
          // start is deliberately not looked at here; a scan runs to completion.
          if (tmr_zero) begin
            for (int i = 0; i < N_CH - 1; i++) begin
              if (sel_q == SEL_W'(i)) shadow[i] <= bus.f;
            end
            if (sel_q != LAST_SEL) begin
              sel_q <= sel_q + SEL_W'(1);
            end else begin
              // Final channel is taken live so the frame is complete on this edge.
              frame_q       <= {bus.f, shadow};
              frame_valid_q <= 1'b1;
              sel_q         <= '0;
              state         <= ST_OUT;
            end
          end
        end

        ST_OUT: begin
          // frame_q is left untouched after the handshake; it only changes on
          // the next entry to OUT.
          if (hs) begin
            frame_valid_q <= 1'b0;
            if (bus.cont || bus.start) begin
              state <= ST_SCAN;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        default: begin
          state         <= ST_IDLE;
          sel_q         <= '0;
          frame_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel         = sel_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Upstream controller for the 4:1 bit mux (mux41): drives the mux select and captures its output `f`. It scans select codes 0..3 in order and waits a programmable settle time after each select change. It samples `f` once per channel and packs the four samples into a 4-bit frame. The frame is delivered downstream over a valid/ready handshake, as single-shot (`start`) or back-to-back (`cont`) scans.

Parameters:
- SETTLE, default 1: extra clock cycles `sel` is held before `f` is sampled; legal range 0..15; each channel occupies SETTLE+1 cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request one scan; honoured only in IDLE.
- cont  input  1  continuous mode; sampled at the frame handshake.
- f  input  1  mux output; treated as combinational from `sel`.
- sel  output  2  mux select; registered.
- frame  output  4  packed samples; frame[i] = f sampled while sel==i.
- frame_valid  output  1  frame available.
- frame_ready  input  1  downstream accepts the frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, sel = 0, frame = 0, frame_valid = 0, busy = 0.
  - Internal counter and shadow register are cleared.
  - Reset mid-scan aborts the scan: no partial frame is ever emitted.
- States: IDLE, SCAN, OUT.
- IDLE:
  - sel = 0.
  - On an edge with start = 1: enter SCAN, sel = 0, cnt = SETTLE.
- SCAN:
  - Each edge with cnt != 0: cnt decrements.
  - Edge with cnt == 0: shadow[sel] <= f.
    - If sel < 3: sel increments, cnt reloads to SETTLE.
    - If sel == 3: frame <= {f, shadow[2:0]}, frame_valid <= 1, sel <= 0, enter OUT.
  - start is ignored while in SCAN.
- Latency: if start is accepted at edge k, frame_valid rises at edge k + 4*(SETTLE+1).
- OUT:
  - frame and frame_valid are held stable until frame_ready = 1 (standard valid/ready rule).
  - On an edge with frame_valid & frame_ready: frame_valid <= 0.
    - If cont = 1 or start = 1: enter SCAN with sel = 0, cnt = SETTLE.
    - Else: enter IDLE.
  - Backpressure stalls scanning; sel is held at 0 and no sampling occurs.
- frame keeps its last value after the handshake; it changes only when entering OUT.
- Continuous mode, ready tied high: frame period = 4*(SETTLE+1) + 1 cycles, with frame_valid high for 1 cycle per frame.
- Changes on f during the settle window have no effect; only the value present in the cnt == 0 cycle is captured.
- Widths:
  - sel wraps only via the explicit reset to 0 after channel 3; it never counts past 3.
  - cnt is 4 bits.

Decomposition:
- Shared include `mux_scan_defs.vh` holds:
  - state encodings `ST_IDLE = 2'd0`, `ST_SCAN = 2'd1`, `ST_OUT = 2'd2`;
  - `N_CH = 4`;
  - `SEL_W = 2`.
- One natural sub-module, `settle_timer`:
  - loadable 4-bit down-counter (load, value, zero flag);
  - instantiated once for the SCAN settle countdown.
- FSM, shadow register and handshake stay in the top module.

Test Plan:
- Static inputs a=0, b=1, c=1, d=0 on the mux41 instance; SETTLE=1; start pulse at edge 0 -> sel sequence 0,0,1,1,2,2,3,3; frame_valid rises at edge 8 with frame = 4'b0110; busy high for edges 1-8.
- Same setup, frame_ready held low 5 cycles after valid -> frame stays 4'b0110, frame_valid stays 1, sel stays 0, no new scan; ready high -> IDLE next edge, frame_valid = 0.
- cont=1, frame_ready=1, SETTLE=1, inputs a=1, b=0, c=0, d=1 -> frame = 4'b1001 with frame_valid pulsing for 1 cycle every 9 cycles over 3 frames; dropping cont -> IDLE after the current handshake.
- Assert rst_n low while sel==2 mid-scan -> sel, frame and frame_valid go to 0 immediately; after release, no frame_valid without a new start.
- start re-pulsed during SCAN -> ignored: exactly one frame, and valid timing is unchanged.
- SETTLE=0, inputs a=1, b=1, c=0, d=0 -> sel changes every cycle; frame_valid at edge 4 with frame = 4'b0011.
